// File: rtl/regs_forward_sb_pkg.sv
// regs_forward_sb_pkg: shared decode types for the forwarding/scoreboard slice
package regs_forward_sb_pkg;
   localparam int REG_NUM = 32;
   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] uint32_t;
   typedef struct packed {
      logic      we;
      reg_addr_t waddr;
      uint32_t   wrdata;
      logic      valid;
   } fwd_req_t;
endpackage

// File: rtl/regs_forward_sb_scoreboard.sv
// reg_scoreboard: per-register pending counters for in-flight long-latency writes
module reg_scoreboard
   import regs_forward_sb_pkg::*;
#(
   parameter int READ_PORTS  = 2,
   parameter int WRITE_PORTS = 1,
   parameter int CNT_WIDTH   = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [WRITE_PORTS-1:0]      issue_we,
   input  logic [WRITE_PORTS-1:0][4:0] issue_waddr,
   input  logic [WRITE_PORTS-1:0]      complete_we,
   input  logic [WRITE_PORTS-1:0][4:0] complete_waddr,
   input  logic [READ_PORTS-1:0][4:0]  raddr,
   output logic [READ_PORTS-1:0]       pending,
   output logic                        sb_err
);
   localparam int MAX = 2**CNT_WIDTH - 1;
   logic [CNT_WIDTH-1:0] cnt     [REG_NUM];
   logic [CNT_WIDTH-1:0] cnt_nxt [REG_NUM];
   logic [REG_NUM-1:0]   bad;
   // r0 is hardwired, so writes aimed at it never count
   function automatic int hits(input logic [WRITE_PORTS-1:0] we,
                               input logic [WRITE_PORTS-1:0][4:0] addr, input int r);
      int n;
      n = 0;
      for (int k = 0; k < WRITE_PORTS; k++)
         if (we[k] && addr[k] == 5'(r) && r != 0) n++;
      return n;
   endfunction
   function automatic logic [CNT_WIDTH:0] sat(input int n);
      return n > MAX ? {1'b1, CNT_WIDTH'(MAX)} : n < 0 ? {1'b1, {CNT_WIDTH{1'b0}}} : {1'b0, CNT_WIDTH'(n)};
   endfunction
   always_comb begin
      for (int r = 0; r < REG_NUM; r++)
         {bad[r], cnt_nxt[r]} = sat(int'(cnt[r]) + hits(issue_we, issue_waddr, r) - hits(complete_we, complete_waddr, r));
      for (int i = 0; i < READ_PORTS; i++)
         pending[i] = int'(cnt[raddr[i]]) > hits(complete_we, complete_waddr, int'(raddr[i]));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < REG_NUM; r++) cnt[r] <= '0;
         sb_err <= 1'b0;
      end else begin
         for (int r = 0; r < REG_NUM; r++) cnt[r] <= cnt_nxt[r];
         sb_err <= sb_err | (|bad);
      end
   end
endmodule

// File: rtl/regs_forward_sb.sv
// regs_forward_sb: multi-stage decode operand forwarding with scoreboard stall
module regs_forward_sb
   import regs_forward_sb_pkg::*;
#(
   parameter int READ_PORTS  = 2,
   parameter int WRITE_PORTS = 1,
   parameter int FWD_STAGES  = 2,
   parameter int CNT_WIDTH   = 2
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [READ_PORTS-1:0][4:0]               regs_raddr_i,
   input  logic [READ_PORTS-1:0][31:0]              regs_rddata_i,
   input  fwd_req_t [FWD_STAGES-1:0][WRITE_PORTS-1:0] fwd_i,
   input  logic [WRITE_PORTS-1:0]                   issue_we_i,
   input  logic [WRITE_PORTS-1:0][4:0]              issue_waddr_i,
   input  logic [WRITE_PORTS-1:0]                   complete_we_i,
   input  logic [WRITE_PORTS-1:0][4:0]              complete_waddr_i,
   output logic [READ_PORTS-1:0][31:0]              regs_rddata_o,
   output logic                                     stall_o,
   output logic                                     sb_err_o
);
   logic [READ_PORTS-1:0] pending, hit_wait;
   reg_scoreboard #(.READ_PORTS(READ_PORTS), .WRITE_PORTS(WRITE_PORTS), .CNT_WIDTH(CNT_WIDTH)) u_sb (
      .clk(clk), .rst(rst),
      .issue_we(issue_we_i), .issue_waddr(issue_waddr_i),
      .complete_we(complete_we_i), .complete_waddr(complete_waddr_i),
      .raddr(regs_raddr_i), .pending(pending), .sb_err(sb_err_o)
   );
   // scan oldest to youngest so the last match (nearest stage, highest slot) wins
   always_comb begin
      regs_rddata_o = regs_rddata_i;
      hit_wait = '0;
      for (int i = 0; i < READ_PORTS; i++)
         if (regs_raddr_i[i] != 5'd0)
            for (int s = FWD_STAGES-1; s >= 0; s--)
               for (int p = 0; p < WRITE_PORTS; p++)
                  if (fwd_i[s][p].we && fwd_i[s][p].waddr == regs_raddr_i[i]) begin
                     regs_rddata_o[i] = fwd_i[s][p].wrdata;
                     hit_wait[i] = !fwd_i[s][p].valid;
                  end
   end
   assign stall_o = |(hit_wait | pending);
endmodule

// File: tb/tb_regs_forward_sb.sv
// tb_regs_forward_sb: directed and randomized checks against a behavioural model
module tb_regs_forward_sb;
   import regs_forward_sb_pkg::*;
   localparam int RP = 2, WP = 2, FS = 2, CW = 2, MAXC = 3;
   logic clk = 0, rst;
   logic [RP-1:0][4:0] raddr;
   logic [RP-1:0][31:0] rdata_i, rdata_o;
   fwd_req_t [FS-1:0][WP-1:0] fwd;
   logic [WP-1:0] issue_we, complete_we;
   logic [WP-1:0][4:0] issue_waddr, complete_waddr;
   logic stall, sb_err;
   int n_checks = 0, n_fail = 0;
   int cnt_m [32];
   bit err_m;

   regs_forward_sb #(.READ_PORTS(RP), .WRITE_PORTS(WP), .FWD_STAGES(FS), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .regs_raddr_i(raddr), .regs_rddata_i(rdata_i), .fwd_i(fwd),
      .issue_we_i(issue_we), .issue_waddr_i(issue_waddr),
      .complete_we_i(complete_we), .complete_waddr_i(complete_waddr),
      .regs_rddata_o(rdata_o), .stall_o(stall), .sb_err_o(sb_err)
   );

   always #5 clk = ~clk;

   function automatic int n_complete(input int a);
      int n = 0;
      for (int k = 0; k < WP; k++) if (complete_we[k] && int'(complete_waddr[k]) == a && a != 0) n++;
      return n;
   endfunction

   // nearest source: youngest stage first, later slot first
   function automatic logic [32:0] nearest(input int i);
      for (int s = 0; s < FS; s++)
         for (int p = WP-1; p >= 0; p--)
            if (raddr[i] != 0 && fwd[s][p].we && fwd[s][p].waddr == raddr[i])
               return {fwd[s][p].valid, fwd[s][p].wrdata};
      return {1'b1, rdata_i[i]};
   endfunction

   function automatic logic [31:0] exp_rdata(input int i);
      logic [32:0] h = nearest(i);
      return h[31:0];
   endfunction

   function automatic logic exp_stall();
      logic st = 0;
      for (int i = 0; i < RP; i++) begin
         logic [32:0] h = nearest(i);
         if (raddr[i] != 0 && (!h[32] || cnt_m[raddr[i]] - n_complete(int'(raddr[i])) > 0)) st = 1;
      end
      return st;
   endfunction

   task automatic tick();
      if (rst) begin
         foreach (cnt_m[r]) cnt_m[r] = 0;
         err_m = 0;
      end else
         for (int r = 1; r < 32; r++) begin
            int n = cnt_m[r] - n_complete(r);
            for (int k = 0; k < WP; k++) if (issue_we[k] && int'(issue_waddr[k]) == r) n++;
            if (n > MAXC) begin n = MAXC; err_m = 1; end
            if (n < 0) begin n = 0; err_m = 1; end
            cnt_m[r] = n;
         end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      raddr = '0; rdata_i = '0; fwd = '0;
      issue_we = '0; issue_waddr = '0; complete_we = '0; complete_waddr = '0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1;
      tick(); tick();
      rst = 0;
      raddr[0] = 5'd12; raddr[1] = 5'd31; rdata_i[0] = 32'h1111; rdata_i[1] = 32'h2222;
      #1;
      n_checks++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", sb_err); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
      n_checks++; if (rdata_o[1] !== 32'h2222) begin n_fail++; $display("FAIL reset_passthru: got %h want 00002222", rdata_o[1]); end
   endtask

   task automatic test_priority();
      clear_inputs();
      raddr[0] = 5'd5;
      fwd[0][0] = '{we: 1, waddr: 5, wrdata: 32'hAAAA0000, valid: 1};
      fwd[1][0] = '{we: 1, waddr: 5, wrdata: 32'h12345678, valid: 1};
      #1;
      n_checks++; if (rdata_o[0] !== 32'hAAAA0000) begin n_fail++; $display("FAIL prio_ex: got %h want AAAA0000", rdata_o[0]); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL prio_stall: got %b want 0", stall); end
      fwd[0][0].we = 0;
      #1;
      n_checks++; if (rdata_o[0] !== 32'h12345678) begin n_fail++; $display("FAIL prio_wb: got %h want 12345678", rdata_o[0]); end
   endtask

   task automatic test_dual_issue();
      clear_inputs();
      raddr[0] = 5'd7;
      fwd[0][0] = '{we: 1, waddr: 7, wrdata: 32'h1, valid: 1};
      fwd[0][1] = '{we: 1, waddr: 7, wrdata: 32'h2, valid: 1};
      #1;
      n_checks++; if (rdata_o[0] !== 32'h2) begin n_fail++; $display("FAIL dual_tie: got %h want 00000002", rdata_o[0]); end
   endtask

   task automatic test_load_use();
      clear_inputs();
      raddr[1] = 5'd3;
      fwd[0][0] = '{we: 1, waddr: 3, wrdata: 32'h0, valid: 0};
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL loaduse_stall: got %b want 1", stall); end
      fwd[0][0] = '0;
      fwd[1][0] = '{we: 1, waddr: 3, wrdata: 32'hDEAD, valid: 1};
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL loaduse_release: got %b want 0", stall); end
      n_checks++; if (rdata_o[1] !== 32'hDEAD) begin n_fail++; $display("FAIL loaduse_data: got %h want 0000DEAD", rdata_o[1]); end
   endtask

   task automatic test_scoreboard();
      clear_inputs();
      issue_we[0] = 1; issue_waddr[0] = 5'd9;
      tick();
      issue_we = '0;
      raddr[0] = 5'd9; rdata_i[0] = 32'h77;
      for (int c = 1; c <= 3; c++) begin
         #1;
         n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sb_wait_c%0d: got %b want 1", c, stall); end
         tick();
      end
      complete_we[1] = 1; complete_waddr[1] = 5'd9;
      fwd[1][0] = '{we: 1, waddr: 9, wrdata: 32'h55, valid: 1};
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sb_done_stall: got %b want 0", stall); end
      n_checks++; if (rdata_o[0] !== 32'h55) begin n_fail++; $display("FAIL sb_done_data: got %h want 00000055", rdata_o[0]); end
      tick();
      clear_inputs();
      raddr[0] = 5'd9;
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sb_drained: got %b want 0", stall); end
   endtask

   task automatic test_counter_edges();
      clear_inputs();
      issue_we[0] = 1; issue_waddr[0] = 5'd4;
      repeat (4) tick();
      n_checks++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b want 1", sb_err); end
      complete_we[0] = 1; complete_waddr[0] = 5'd4;
      tick();
      issue_we = '0;
      raddr[0] = 5'd4;
      // draining three completions proves the count held at 3
      for (int c = 3; c >= 1; c--) begin
         #1;
         n_checks++; if (stall !== (c > 1)) begin n_fail++; $display("FAIL drain_cnt%0d: got %b want %b", c, stall, c > 1); end
         tick();
      end
      complete_waddr[0] = 5'd6; raddr[0] = 5'd6;
      tick();
      complete_we = '0;
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL unf_cnt: got %b want 0", stall); end
      n_checks++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL unf_err: got %b want 1", sb_err); end
      issue_we[0] = 1; issue_waddr[0] = 5'd4;
      tick(); tick();
      issue_we = '0; raddr[0] = 5'd4;
      rst = 1;
      tick();
      rst = 0;
      #1;
      n_checks++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", sb_err); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_cnt: got %b want 0", stall); end
   endtask

   task automatic test_zero();
      clear_inputs();
      issue_we[1] = 1; issue_waddr[1] = 5'd0;
      fwd[0][0] = '{we: 1, waddr: 0, wrdata: 32'hFFFF, valid: 0};
      rdata_i[0] = 32'h0;
      #1;
      n_checks++; if (rdata_o[0] !== 32'h0) begin n_fail++; $display("FAIL zero_data: got %h want 00000000", rdata_o[0]); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall: got %b want 0", stall); end
      tick();
      fwd = '0; issue_we = '0;
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_cnt: got %b want 0", stall); end
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 400; cyc++) begin
         rst = ($urandom_range(0, 63) == 0);
         for (int i = 0; i < RP; i++) begin
            raddr[i] = 5'($urandom_range(0, 7));
            rdata_i[i] = $urandom;
         end
         for (int s = 0; s < FS; s++)
            for (int p = 0; p < WP; p++) begin
               fwd[s][p].we = 1'($urandom_range(0, 1));
               fwd[s][p].waddr = 5'($urandom_range(0, 7));
               fwd[s][p].wrdata = $urandom;
               fwd[s][p].valid = ($urandom_range(0, 3) != 0);
            end
         for (int k = 0; k < WP; k++) begin
            issue_we[k] = ($urandom_range(0, 3) == 0);
            issue_waddr[k] = 5'($urandom_range(0, 7));
            complete_we[k] = ($urandom_range(0, 3) == 0);
            complete_waddr[k] = 5'($urandom_range(0, 7));
         end
         #1;
         for (int i = 0; i < RP; i++) begin
            n_checks++;
            if (rdata_o[i] !== exp_rdata(i)) begin n_fail++; $display("FAIL rand_rdata%0d cyc %0d: got %h want %h", i, cyc, rdata_o[i], exp_rdata(i)); end
         end
         n_checks++; if (stall !== exp_stall()) begin n_fail++; $display("FAIL rand_stall cyc %0d: got %b want %b", cyc, stall, exp_stall()); end
         n_checks++; if (sb_err !== err_m) begin n_fail++; $display("FAIL rand_err cyc %0d: got %b want %b", cyc, sb_err, err_m); end
         tick();
      end
      rst = 0;
   endtask

   initial begin
      test_reset();
      test_priority();
      test_dual_issue();
      test_load_use();
      test_scoreboard();
      test_counter_edges();
      test_zero();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
